// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM access arbiter.
package rom_arb_pkg;

  // Default ROM geometry: 64 words of 8 bits.
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  // Width of the optional grant/conflict statistics counters.
  localparam int STATS_W = 16;

  // Identifies which requester owns a transaction.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // One entry of the in-flight ownership pipeline.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Fixed-depth shift register carrying ownership tags alongside ROM reads.
// Shifts every cycle, never stalls; clearing empties every stage.
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] stage_q;

  // Advance every tag one stage per clock; stage 0 takes the new entry.
  // NOTE: every stage is reset, not just the head -- a stale valid bit left
  // anywhere in the chain would emerge later as a phantom response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM between two requesters.
// One access per cycle; a tag pipeline routes each returning word to the
// requester that issued it, ROM_LAT+2 cycles after its grant.
// Optional statistics counters: define ROM_ACCESS_ARBITER_STATS_EN.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = 1            // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_d
`ifdef ROM_ACCESS_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1,
  output logic [STATS_W-1:0] conflict_cnt
`endif
);

  // One stage per ROM latency edge plus the stage that lines up with rom_d.
  localparam int TAG_DEPTH = ROM_LAT + 1;

  req_id_e           last_gnt_q;
  logic [ADDR_W-1:0] rom_a_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic    gnt0_c, gnt1_c;
  logic    grant_any;
  req_id_e grant_id;
  tag_t    tag_in, tag_out;

  // Round-robin decision: on contention the requester not served last wins.
  // NOTE: both grants get a default before any branch so no path leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (req0 && req1) begin
      if (last_gnt_q == REQ1) gnt0_c = 1'b1;
      else                    gnt1_c = 1'b1;
    end else begin
      gnt0_c = req0;
      gnt1_c = req1;
    end
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign grant_any = gnt0_c | gnt1_c;
  assign grant_id  = gnt1_c ? REQ1 : REQ0;

  // Latch the granted address into the ROM and remember who was served.
  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_a_q    <= '0;
      last_gnt_q <= REQ1;
    end else if (grant_any) begin
      rom_a_q    <= gnt1_c ? addr1 : addr0;
      last_gnt_q <= grant_id;
    end
  end

  assign tag_in = '{valid: grant_any, id: grant_id};

  rom_arb_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Route the ROM word to the owner of the tag leaving the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tag_out.valid && (tag_out.id == REQ0);
      rvalid1_q <= tag_out.valid && (tag_out.id == REQ1);
      if (tag_out.valid && (tag_out.id == REQ0)) rdata0_q <= rom_d;
      if (tag_out.valid && (tag_out.id == REQ1)) rdata1_q <= rom_d;
    end
  end

  assign rom_a   = rom_a_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

`ifdef ROM_ACCESS_ARBITER_STATS_EN
  logic [STATS_W-1:0] gnt_cnt0_q, gnt_cnt1_q, conflict_cnt_q;

  // Saturating grant and contention counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q     <= '0;
      gnt_cnt1_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (gnt0_c)         gnt_cnt0_q     <= sat_inc(gnt_cnt0_q);
      if (gnt1_c)         gnt_cnt1_q     <= sat_inc(gnt_cnt1_q);
      if (req0 && req1)   conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
